// File: rtl/operand_fetch_pkg.sv
// ============================================================================
// operand_fetch_pkg: shared widths, register count and operand types.
// Rev 1.0
// ============================================================================
`default_nettype none

package operand_fetch_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ZERO_REG = '0;

  // Register 0 is hardwired, so it never takes writes or pending marks.
  function automatic logic is_live(input addr_t a);
    return a != ZERO_REG;
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_fetch_if.sv
// ============================================================================
// operand_fetch_if: write-back, fetch request and operand result bundle.
// Rev 1.0
// ============================================================================
`default_nettype none

interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic  wb_en;
  addr_t wb_addr;
  data_t ans_wb;
  logic  rd_req;
  addr_t rs_addr;
  addr_t rt_addr;
  logic  dest_set;
  addr_t dest_addr;
  logic  stall;
  data_t op_a;
  data_t op_b;
  logic  op_valid;
  logic  hazard;

  modport slave (
    input  wb_en, wb_addr, ans_wb, rd_req, rs_addr, rt_addr,
           dest_set, dest_addr, stall,
    output op_a, op_b, op_valid, hazard
  );

  modport master (
    output wb_en, wb_addr, ans_wb, rd_req, rs_addr, rt_addr,
           dest_set, dest_addr, stall,
    input  op_a, op_b, op_valid, hazard
  );

endinterface

`default_nettype wire

// File: rtl/operand_fetch_regfile_2r1w.sv
// ============================================================================
// regfile_2r1w: two-read one-write register array, r0 tied to zero, with
// same-cycle write-to-read bypass. Rev 1.0
// ============================================================================
`default_nettype none

module regfile_2r1w
  import operand_fetch_pkg::*;
(
  input  wire   clk,
  input  wire   reset,
  input  wire   i_we,
  input  addr_t i_waddr,
  input  data_t i_wdata,
  input  addr_t i_raddr_a,
  input  addr_t i_raddr_b,
  output data_t o_rdata_a,
  output data_t o_rdata_b
);

  data_t r_regs [NREGS];
  logic  w_wr_live;

  assign w_wr_live = i_we && is_live(i_waddr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_live) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    if (is_live(i_raddr_a))
      o_rdata_a = (w_wr_live && i_waddr == i_raddr_a) ? i_wdata : r_regs[i_raddr_a];
    if (is_live(i_raddr_b))
      o_rdata_b = (w_wr_live && i_waddr == i_raddr_b) ? i_wdata : r_regs[i_raddr_b];
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// operand_fetch: register-file read stage with bypass, stall hold, held-operand
// refresh and pending-write scoreboard. Rev 1.0
// ============================================================================
`default_nettype none

module operand_fetch
  import operand_fetch_pkg::*;
(
  input  wire               clk,
  input  wire               reset,
  operand_fetch_if.slave    bus
);

  data_t            w_rd_a;
  data_t            w_rd_b;
  logic             w_wr_hit;
  logic             w_blk_a;
  logic             w_blk_b;
  logic             w_accept;
  logic             w_blocked;
  logic [NREGS-1:0] w_pend_nxt;

  logic [NREGS-1:0] r_pend;
  data_t            r_op_a;
  data_t            r_op_b;
  logic             r_valid;
  logic             r_hazard;
  addr_t            r_held_a;
  addr_t            r_held_b;

  regfile_2r1w u_rf (
    .clk       (clk),
    .reset     (reset),
    .i_we      (bus.wb_en),
    .i_waddr   (bus.wb_addr),
    .i_wdata   (bus.ans_wb),
    .i_raddr_a (bus.rs_addr),
    .i_raddr_b (bus.rt_addr),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  assign w_wr_hit  = bus.wb_en && is_live(bus.wb_addr);
  // A source being written this cycle is satisfied by the bypass, not blocked.
  assign w_blk_a   = is_live(bus.rs_addr) && r_pend[bus.rs_addr] &&
                     !(w_wr_hit && bus.wb_addr == bus.rs_addr);
  assign w_blk_b   = is_live(bus.rt_addr) && r_pend[bus.rt_addr] &&
                     !(w_wr_hit && bus.wb_addr == bus.rt_addr);
  assign w_blocked = w_blk_a || w_blk_b;
  assign w_accept  = bus.rd_req && !bus.stall;

  // Set is applied after clear so a same-address set wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_hit)
      w_pend_nxt[bus.wb_addr] = 1'b0;
    if (w_accept && !w_blocked && bus.dest_set && is_live(bus.dest_addr))
      w_pend_nxt[bus.dest_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend   <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_valid  <= 1'b0;
      r_hazard <= 1'b0;
      r_held_a <= '0;
      r_held_b <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (bus.stall) begin
        if (w_wr_hit && r_held_a == bus.wb_addr) r_op_a <= bus.ans_wb;
        if (w_wr_hit && r_held_b == bus.wb_addr) r_op_b <= bus.ans_wb;
      end else if (bus.rd_req) begin
        if (w_blocked) begin
          r_valid  <= 1'b0;
          r_hazard <= 1'b1;
        end else begin
          r_op_a   <= w_rd_a;
          r_op_b   <= w_rd_b;
          r_held_a <= bus.rs_addr;
          r_held_b <= bus.rt_addr;
          r_valid  <= 1'b1;
          r_hazard <= 1'b0;
        end
      end else begin
        r_valid  <= 1'b0;
        r_hazard <= 1'b0;
      end
    end
  end

  assign bus.op_a     = r_op_a;
  assign bus.op_b     = r_op_b;
  assign bus.op_valid = r_valid;
  assign bus.hazard   = r_hazard;

endmodule

`default_nettype wire
